elevator_scan: RTL and testbench

ELEVATOR_SCAN -- requirements
Module: elevator_scan

---
 rtl/elevator_pkg.sv | 21 ++
 rtl/call_latch.sv | 35 +++
 rtl/elevator_scan.sv | 148 ++++++++++++++
 tb/tb_elevator_scan.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the single-car SCAN elevator controller.
package elevator_pkg;

  // Scheduler states of the car.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_e;

  // Travel direction codes as driven on the dir output.
  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  // Default geometry and timing at a 10 Hz tick.
  localparam int DEF_N_FLOORS     = 3;
  localparam int DEF_TRAVEL_TICKS = 20;
  localparam int DEF_DOOR_TICKS   = 30;

endpackage

// File: rtl/call_latch.sv
// Per-floor call capture: rising-edge detection of the call switches and the
// pending-call lamps, which stay lit until the scheduler reports the floor served.
module call_latch
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = DEF_N_FLOORS
) (
  input  logic                clk10,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] i_swh,
  input  logic [N_FLOORS-1:0] i_srv,   // floors served on this edge
  output logic [N_FLOORS-1:0] o_light,
  output logic [N_FLOORS-1:0] o_ev     // call events this cycle
);

  logic [N_FLOORS-1:0] r_swh_q;
  logic [N_FLOORS-1:0] r_light;

  // A held switch produces exactly one event: only the 0->1 transition counts.
  assign o_ev    = i_swh & ~r_swh_q;
  assign o_light = r_light;

  // Register switches and update lamps; a service on the same edge beats a new call.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk10) begin
    if (rst) begin
      r_swh_q <= '0;
      r_light <= '0;
    end else begin
      r_swh_q <= i_swh;
      r_light <= (r_light | o_ev) & ~i_srv;
    end
  end

endmodule

// File: rtl/elevator_scan.sv
// SCAN scheduler for one car: keeps travelling in its direction while calls
// remain ahead, reverses when only calls behind remain, idles when none remain.
module elevator_scan
  import elevator_pkg::*;
#(
  parameter int N_FLOORS     = DEF_N_FLOORS,
  parameter int TRAVEL_TICKS = DEF_TRAVEL_TICKS,
  parameter int DOOR_TICKS   = DEF_DOOR_TICKS,
  localparam int FW   = (N_FLOORS > 2) ? $clog2(N_FLOORS) : 1,
  localparam int TMAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS,
  localparam int TW   = $clog2(TMAX + 1)
) (
  input  logic                clk10,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] swh,
  output logic [N_FLOORS-1:0] light,
  output logic [FW-1:0]       floor,
  output logic [1:0]          dir,
  output logic                door
);

  localparam logic [TW-1:0]       T_TRAVEL = TW'(TRAVEL_TICKS - 1);
  localparam logic [TW-1:0]       T_DOOR   = TW'(DOOR_TICKS - 1);
  localparam logic [N_FLOORS-1:0] ONE      = {{(N_FLOORS-1){1'b0}}, 1'b1};

  state_e        r_state, w_state;
  logic [FW-1:0] r_floor, w_floor;
  logic [1:0]    r_dir,   w_dir;
  logic [TW-1:0] r_timer, w_timer;

  logic [N_FLOORS-1:0] w_ev, w_srv, w_cur_oh, w_new_oh;
  logic [FW-1:0]       w_new_floor;
  logic                w_above, w_below, w_ev_here, w_lit_new;

  call_latch #(.N_FLOORS(N_FLOORS)) u_calls (
    .clk10   (clk10),
    .rst     (rst),
    .i_swh   (swh),
    .i_srv   (w_srv),
    .o_light (light),
    .o_ev    (w_ev)
  );

  assign w_new_floor = (r_dir == DIR_UP) ? r_floor + 1'b1 : r_floor - 1'b1;
  assign w_cur_oh    = ONE << r_floor;
  assign w_new_oh    = ONE << w_new_floor;
  assign w_ev_here   = |(w_ev & w_cur_oh);
  // A call arriving on the same edge as the car counts as served there.
  assign w_lit_new   = |((light | w_ev) & w_new_oh);

  // Summarise pending calls above and below the car.
  always_comb begin
    w_above = 1'b0;
    w_below = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i > int'(r_floor)) w_above = w_above | light[i];
      if (i < int'(r_floor)) w_below = w_below | light[i];
    end
  end

  // Next-state, timer, floor and direction decisions.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    w_state = r_state;
    w_floor = r_floor;
    w_dir   = r_dir;
    w_timer = r_timer;
    w_srv   = '0;
    case (r_state)
      ST_IDLE: begin
        w_srv = w_cur_oh;
        if (w_ev_here) begin
          w_state = ST_DOOR;
          w_timer = T_DOOR;
        end else if (w_above) begin
          w_state = ST_MOVE;
          w_dir   = DIR_UP;
          w_timer = T_TRAVEL;
        end else if (w_below) begin
          w_state = ST_MOVE;
          w_dir   = DIR_DOWN;
          w_timer = T_TRAVEL;
        end
      end
      ST_MOVE: begin
        if (r_timer != '0) begin
          w_timer = r_timer - 1'b1;
        end else begin
          w_floor = w_new_floor;
          w_srv   = w_new_oh;
          if (w_lit_new) begin
            w_state = ST_DOOR;
            w_timer = T_DOOR;
          end else begin
            w_timer = T_TRAVEL;
          end
        end
      end
      ST_DOOR: begin
        w_srv = w_cur_oh;
        if (w_ev_here) begin
          w_timer = T_DOOR;
        end else if (r_timer != '0) begin
          w_timer = r_timer - 1'b1;
        end else if ((r_dir == DIR_UP && w_above) || (r_dir == DIR_DOWN && w_below)) begin
          w_state = ST_MOVE;
          w_timer = T_TRAVEL;
        end else if (w_above) begin
          w_state = ST_MOVE;
          w_dir   = DIR_UP;
          w_timer = T_TRAVEL;
        end else if (w_below) begin
          w_state = ST_MOVE;
          w_dir   = DIR_DOWN;
          w_timer = T_TRAVEL;
        end else begin
          w_state = ST_IDLE;
          w_dir   = DIR_NONE;
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_dir   = DIR_NONE;
        w_timer = '0;
      end
    endcase
  end

  // Scheduler state register; reset abandons any trip and returns to floor 0.
  always_ff @(posedge clk10) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_floor <= '0;
      r_dir   <= DIR_NONE;
      r_timer <= '0;
    end else begin
      r_state <= w_state;
      r_floor <= w_floor;
      r_dir   <= w_dir;
      r_timer <= w_timer;
    end
  end

  assign floor = r_floor;
  assign dir   = r_dir;
  assign door  = (r_state == ST_DOOR);

endmodule

// File: tb/tb_elevator_scan.sv
// Scoreboard bench for elevator_scan (3 floors, 20/30 ticks): each scenario
// queues timed expectations when its stimulus is driven; a negedge checker
// pops and compares them as their cycle comes due.
module tb_elevator_scan;

  logic       clk10;
  logic       rst;
  logic [2:0] swh;
  logic [2:0] light;
  logic [1:0] floor;
  logic [1:0] dir;
  logic       door;

  elevator_scan #(.N_FLOORS(3), .TRAVEL_TICKS(20), .DOOR_TICKS(30)) dut (
    .clk10 (clk10),
    .rst   (rst),
    .swh   (swh),
    .light (light),
    .floor (floor),
    .dir   (dir),
    .door  (door)
  );

  localparam int S_LIGHT = 0, S_FLOOR = 1, S_DIR = 2, S_DOOR = 3;

  typedef struct {
    int unsigned at;
    int          sel;
    int          val;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          n_total = 0;
  int          n_bad   = 0;
  int unsigned cyc     = 0;
  int unsigned b;
  int          act;

  initial begin
    clk10 = 1'b0;
    forever #5 clk10 = ~clk10;
  end

  // cyc = number of rising edges seen; cycle n is the interval after edge n.
  always @(posedge clk10) cyc <= cyc + 1;

  task automatic check(input string tag, input int actual, input int expected);
    n_total++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", tag, cyc, actual, expected);
    end
  endtask

  // Insert keeping the queue ordered by due cycle.
  task automatic expect_at(input int unsigned at, input int sel, input int val, input string tag);
    exp_t x;
    int   i;
    x.at = at; x.sel = sel; x.val = val; x.tag = tag;
    i = sb.size();
    while (i > 0 && sb[i-1].at > at) i--;
    sb.insert(i, x);
  endtask

  // Advance to cycle 'target', landing 1 time unit after a falling edge.
  task automatic goto(input int unsigned target);
    while (cyc < target) begin
      @(negedge clk10);
      #1;
    end
  endtask

  always @(negedge clk10) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      case (e.sel)
        S_LIGHT: act = 32'(light);
        S_FLOOR: act = 32'(floor);
        S_DIR:   act = 32'(dir);
        default: act = 32'(door);
      endcase
      check(e.tag, act, e.val);
    end
  end

  initial begin
    rst = 1'b1;
    swh = 3'b000;
    expect_at(2, S_LIGHT, 0, "rst_light");
    expect_at(2, S_FLOOR, 0, "rst_floor");
    expect_at(2, S_DIR,   0, "rst_dir");
    expect_at(2, S_DOOR,  0, "rst_door");
    goto(3);
    rst = 1'b0;
    goto(5);

    // Call at the current floor while idle: door opens, no lamp.
    b = cyc;
    swh = 3'b001;
    expect_at(b+1,  S_LIGHT, 0, "s1_light");
    expect_at(b+1,  S_DOOR,  1, "s1_door_open");
    expect_at(b+30, S_DOOR,  1, "s1_door_last");
    expect_at(b+31, S_DOOR,  0, "s1_door_closed");
    expect_at(b+31, S_DIR,   0, "s1_dir_idle");
    goto(b+5);  swh = 3'b000;
    goto(b+35);

    // Floor 0 -> 2 trip.
    b = cyc;
    swh = 3'b100;
    expect_at(b+1,  S_LIGHT, 4, "s2_light");
    expect_at(b+2,  S_DIR,   1, "s2_dir_up");
    expect_at(b+21, S_FLOOR, 0, "s2_floor0_hold");
    expect_at(b+22, S_FLOOR, 1, "s2_floor1");
    expect_at(b+41, S_FLOOR, 1, "s2_floor1_hold");
    expect_at(b+42, S_FLOOR, 2, "s2_floor2");
    expect_at(b+42, S_LIGHT, 0, "s2_light_clr");
    expect_at(b+42, S_DOOR,  1, "s2_door_open");
    expect_at(b+71, S_DOOR,  1, "s2_door_last");
    expect_at(b+72, S_DOOR,  0, "s2_door_closed");
    expect_at(b+72, S_DIR,   0, "s2_dir_idle");
    goto(b+3);  swh = 3'b000;
    goto(b+75);

    // From floor 2, calls at 1 and 0: stop at 1, continue down to 0.
    b = cyc;
    swh = 3'b011;
    expect_at(b+1,   S_LIGHT, 3, "s3_light");
    expect_at(b+2,   S_DIR,   2, "s3_dir_down");
    expect_at(b+22,  S_FLOOR, 1, "s3_floor1");
    expect_at(b+22,  S_LIGHT, 1, "s3_light1_clr");
    expect_at(b+22,  S_DOOR,  1, "s3_door1_open");
    expect_at(b+51,  S_DOOR,  1, "s3_door1_last");
    expect_at(b+52,  S_DOOR,  0, "s3_door1_closed");
    expect_at(b+52,  S_DIR,   2, "s3_dir_still_down");
    expect_at(b+71,  S_FLOOR, 1, "s3_floor1_hold");
    expect_at(b+72,  S_FLOOR, 0, "s3_floor0");
    expect_at(b+72,  S_LIGHT, 0, "s3_light_clr");
    expect_at(b+102, S_DIR,   0, "s3_dir_idle");
    goto(b+3);  swh = 3'b000;
    goto(b+105);

    // Trip 0 -> 2 with a floor-0 call placed during the trip: reversal.
    b = cyc;
    swh = 3'b100;
    expect_at(b+1,   S_LIGHT, 4, "s4_light");
    expect_at(b+11,  S_LIGHT, 5, "s4_light_both");
    expect_at(b+42,  S_FLOOR, 2, "s4_floor2");
    expect_at(b+42,  S_LIGHT, 1, "s4_light_left");
    expect_at(b+72,  S_DIR,   2, "s4_dir_reversed");
    expect_at(b+72,  S_DOOR,  0, "s4_door_closed");
    expect_at(b+92,  S_FLOOR, 1, "s4_floor1_down");
    expect_at(b+111, S_FLOOR, 1, "s4_floor1_hold");
    expect_at(b+112, S_FLOOR, 0, "s4_floor0");
    expect_at(b+112, S_LIGHT, 0, "s4_light_clr");
    expect_at(b+112, S_DOOR,  1, "s4_door0_open");
    expect_at(b+142, S_DIR,   0, "s4_dir_idle");
    goto(b+3);  swh = 3'b000;
    goto(b+10); swh = 3'b001;
    goto(b+15); swh = 3'b000;
    goto(b+145);

    // One-cycle reset mid-move with light=110.
    b = cyc;
    swh = 3'b110;
    expect_at(b+1,  S_LIGHT, 6, "s5_light");
    expect_at(b+2,  S_DIR,   1, "s5_dir_up");
    expect_at(b+10, S_LIGHT, 6, "s5_light_pre_rst");
    expect_at(b+11, S_FLOOR, 0, "s5_rst_floor");
    expect_at(b+11, S_LIGHT, 0, "s5_rst_light");
    expect_at(b+11, S_DOOR,  0, "s5_rst_door");
    expect_at(b+11, S_DIR,   0, "s5_rst_dir");
    goto(b+3);  swh = 3'b000;
    goto(b+10); rst = 1'b1;
    goto(b+11); rst = 1'b0;
    goto(b+15);

    // Reset after the car has left floor 0.
    b = cyc;
    swh = 3'b100;
    expect_at(b+22, S_FLOOR, 1, "s6_floor1");
    expect_at(b+31, S_FLOOR, 0, "s6_rst_floor");
    expect_at(b+31, S_LIGHT, 0, "s6_rst_light");
    expect_at(b+31, S_DIR,   0, "s6_rst_dir");
    goto(b+3);  swh = 3'b000;
    goto(b+30); rst = 1'b1;
    goto(b+31); rst = 1'b0;
    goto(b+35);

    // Switch held through reset and then for 300 cycles: one service only.
    swh = 3'b100;
    rst = 1'b1;
    goto(cyc+2);
    rst = 1'b0;
    b = cyc;
    expect_at(b+1,   S_LIGHT, 4, "s7_light_after_rst");
    expect_at(b+2,   S_DIR,   1, "s7_dir_up");
    expect_at(b+42,  S_FLOOR, 2, "s7_floor2");
    expect_at(b+42,  S_LIGHT, 0, "s7_light_clr");
    expect_at(b+42,  S_DOOR,  1, "s7_door_open");
    expect_at(b+72,  S_DOOR,  0, "s7_door_closed");
    expect_at(b+72,  S_DIR,   0, "s7_dir_idle");
    expect_at(b+150, S_LIGHT, 0, "s7_no_relight_mid");
    expect_at(b+300, S_LIGHT, 0, "s7_no_relight_end");
    expect_at(b+300, S_FLOOR, 2, "s7_floor_end");
    expect_at(b+300, S_DOOR,  0, "s7_door_end");
    goto(b+301); swh = 3'b000;
    goto(cyc+3);

    // Current-floor call while the door is open reloads the door timer.
    b = cyc;
    swh = 3'b100;
    expect_at(b+1,  S_DOOR,  1, "s8_door_open");
    expect_at(b+1,  S_LIGHT, 0, "s8_light");
    expect_at(b+11, S_LIGHT, 0, "s8_light_reload");
    expect_at(b+31, S_DOOR,  1, "s8_door_extended");
    expect_at(b+40, S_DOOR,  1, "s8_door_last");
    expect_at(b+41, S_DOOR,  0, "s8_door_closed");
    goto(b+2);  swh = 3'b000;
    goto(b+10); swh = 3'b100;
    goto(b+12); swh = 3'b000;
    goto(b+45);

    // Call for floor 1 arriving on the very edge the car reaches floor 1.
    b = cyc;
    swh = 3'b001;
    expect_at(b+1,   S_LIGHT, 1, "s9_light");
    expect_at(b+22,  S_FLOOR, 1, "s9_floor1");
    expect_at(b+22,  S_LIGHT, 1, "s9_arrival_served");
    expect_at(b+200, S_FLOOR, 0, "s9_floor_end");
    expect_at(b+200, S_LIGHT, 0, "s9_light_end");
    expect_at(b+200, S_DIR,   0, "s9_dir_end");
    goto(b+3);  swh = 3'b000;
    goto(b+21); swh = 3'b010;
    goto(b+24); swh = 3'b000;
    goto(b+202);

    if (sb.size() != 0) check("sb_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
